serial_accum_adder: RTL and testbench
=====================================

SERIAL_ACCUM_ADDER -- requirements
Module: serial_accum_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 St  input  1  start request, sampled only in IDLE.
REQ-005 Acc  input  1  1 = keep accumulator contents as X operand; 0 = load Xin.
REQ-006 Mode  input  1  0 = add (X+Y), 1 = subtract (X-Y); sampled with St.
REQ-007 Xin  input  WIDTH  X operand, sampled with St when Acc=0.
REQ-008 Yin  input  WIDTH  Y operand (addend), sampled with St.
REQ-009 Busy  output  1  high while a serial operation is in progress.
REQ-010 Done  output  1  one-cycle pulse: result valid.
REQ-011 Sum  output  WIDTH  accumulator register contents.
REQ-012 Cout  output  1  final carry (sub: 1 = no borrow).
REQ-013 Ovf  output  1  signed overflow of the last operation.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE: St=1 at an edge loads addend register <= Yin, accumulator <= Xin (Acc=0) or unchanged (Acc=1), carry FF <= Mode, bit counter <= 0, latched mode <= Mode; next state SHIFT.
REQ-016 SHIFT, each cycle: y = addend[0] XOR latched mode; s = acc[0]^y^carry; carry <= majority(acc[0], y, carry); accumulator shifts right with s into MSB; addend shifts right with 0 into MSB; counter increments.
REQ-017 SHIFT -> DONE on the edge completing the WIDTH-th shift; counter width ceil(log2(WIDTH))+1, no wrap before termination.
REQ-018 DONE: Done=1 exactly one cycle, Cout = carry FF; next state IDLE unconditionally.
REQ-019 Latency: St sampled at edge k -> Busy high cycles k+1..k+WIDTH, Done high cycle k+WIDTH+1.
REQ-020 Busy = 1 in SHIFT only; Done = 1 in DONE only.
REQ-021 St while in SHIFT or DONE is ignored, not queued; Xin/Yin/Mode/Acc changes during SHIFT have no effect.
REQ-022 St held high continuously restarts one cycle after each Done (back-to-back, WIDTH+2 cycle period).
REQ-023 Sum and Cout hold the last result until the next St is accepted; Sum valid modulo 2^WIDTH.

Reset
REQ-024 Rst_n low, asynchronously and at any time including mid-SHIFT: state <= IDLE, accumulator, addend, counter, carry, Cout, Ovf <= 0; Busy=0, Done=0, Sum=0.
REQ-025 Partial results are discarded on reset; first St after release starts a fresh operation.

Configuration
REQ-026 Macro SERIAL_ACCUM_ADDER_OVF_EN defined: carry-in to the MSB bit position captured on the final shift; Ovf <= captured carry XOR final carry, updated at DONE entry, held until next St accepted.
REQ-027 Macro undefined: no overflow capture logic; Ovf tied 0 permanently.

Verification (WIDTH=8)
REQ-028 Add: Acc=0, Mode=0, Xin=0x35, Yin=0x4A, St pulse -> Done on 9th edge after sampling St, Sum=0x7F, Cout=0, Ovf=0.
REQ-029 Wrap/subtract: 0xFF+0x01 -> Sum=0x00, Cout=1; then Mode=1, 0x10-0x20 -> Sum=0xF0, Cout=0.
REQ-030 Accumulate/overflow: after Sum=0x7F, St with Acc=1, Mode=0, Yin=0x01 -> Sum=0x80, Ovf=1 (macro defined) / 0 (undefined).
REQ-031 St pulses at shift cycles 2 and 5 of a running operation -> ignored, single Done, result unchanged vs. clean run.
REQ-032 Rst_n low for 1 ns mid-SHIFT (counter=4), asynchronous to CLK -> Busy, Sum, Cout drop to 0 immediately; no Done; next St yields correct result.

Source files
------------

// File: rtl/serial_accum_adder.sv
// Bit-serial add/subtract accumulator: one result bit per clock, LSB first.
// Optional signed-overflow flag is built only with SERIAL_ACCUM_ADDER_OVF_EN.
//
// Ports:
//   CLK   - clock, rising edge
//   Rst_n - asynchronous active-low reset
//   St    - start request, sampled only in IDLE
//   Acc   - 1: keep accumulator as X operand, 0: load Xin
//   Mode  - 0: X+Y, 1: X-Y (sampled with St)
//   Xin   - X operand (used when Acc=0)
//   Yin   - Y operand
//   Busy  - high while shifting
//   Done  - one-cycle result-valid pulse
//   Sum   - accumulator contents
//   Cout  - final carry (subtract: 1 = no borrow)
//   Ovf   - signed overflow of the last operation (0 without the macro)
module serial_accum_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Rst_n,
    input  logic             St,
    input  logic             Acc,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] add_q, add_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             cout_q, cout_d;

    logic y_bit;
    logic s_bit;
    logic maj;

    // Subtraction is X + ~Y + 1: invert the Y bit and preload carry with 1.
    always_comb begin
        y_bit = add_q[0] ^ mode_q;
        s_bit = acc_q[0] ^ y_bit ^ carry_q;
        maj   = (acc_q[0] & y_bit)
              | (acc_q[0] & carry_q)
              | (y_bit & carry_q);
    end

`ifdef SERIAL_ACCUM_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        add_d   = add_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        cout_d  = cout_q;
`ifdef SERIAL_ACCUM_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (St) begin
                    add_d   = Yin;
                    carry_d = Mode;
                    mode_d  = Mode;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                    if (!Acc) begin
                        acc_d = Xin;
                    end
                end
            end
            S_SHIFT: begin
                carry_d = maj;
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                add_d   = {1'b0, add_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cout_d  = maj;
`ifdef SERIAL_ACCUM_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB position.
                    ovf_d   = carry_q ^ maj;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            add_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            add_q   <= add_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ACCUM_ADDER_OVF_EN
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

    assign Busy = (state_q == S_SHIFT);
    assign Done = (state_q == S_DONE);
    assign Sum  = acc_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_accum_adder.sv
// Directed self-checking bench for serial_accum_adder at WIDTH=8.
// Expected values are hand-computed constants.
`timescale 1ns/100ps
module tb_serial_accum_adder;

    logic       CLK;
    logic       Rst_n;
    logic       St;
    logic       Acc;
    logic       Mode;
    logic [7:0] Xin;
    logic [7:0] Yin;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       Cout;
    logic       Ovf;

    int tests;
    int fails;

`ifdef SERIAL_ACCUM_ADDER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    serial_accum_adder #(.WIDTH(8)) dut (
        .CLK  (CLK),
        .Rst_n(Rst_n),
        .St   (St),
        .Acc  (Acc),
        .Mode (Mode),
        .Xin  (Xin),
        .Yin  (Yin),
        .Busy (Busy),
        .Done (Done),
        .Sum  (Sum),
        .Cout (Cout),
        .Ovf  (Ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Start an op, check Busy through the 8 shifts, then the DONE cycle.
    task automatic run_op(input string tag, input logic acc,
                          input logic mode, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] sum_e,
                          input logic cout_e, input logic ovf_e);
        Acc  = acc;
        Mode = mode;
        Xin  = x;
        Yin  = y;
        St   = 1'b1;
        cyc();
        St = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, Busy, 1);
            chk({tag, "_nodone"}, Done, 0);
            cyc();
        end
        chk({tag, "_done"}, Done, 1);
        chk({tag, "_busy0"}, Busy, 0);
        chk({tag, "_sum"}, Sum, sum_e);
        chk({tag, "_cout"}, Cout, cout_e);
        chk({tag, "_ovf"}, Ovf, ovf_e);
        cyc();
        chk({tag, "_done0"}, Done, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Rst_n = 1'b0;
        St    = 1'b0;
        Acc   = 1'b0;
        Mode  = 1'b0;
        Xin   = 8'h00;
        Yin   = 8'h00;
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_ovf", Ovf, 0);
        #11 Rst_n = 1'b1;
        cyc();

        run_op("add", 1'b0, 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
        run_op("accum", 1'b1, 1'b0, 8'hAA, 8'h01, 8'h80, 1'b0, OVF_EXP);
        run_op("wrap", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("sub", 1'b0, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);

        Xin = 8'h55;
        Yin = 8'h66;
        cyc();
        cyc();
        chk("hold_sum", Sum, 8'hF0);
        chk("hold_cout", Cout, 0);
        chk("hold_idle", Busy, 0);

        // St pulses in shift cycles 2 and 5, plus operand churn.
        Acc  = 1'b0;
        Mode = 1'b0;
        Xin  = 8'h35;
        Yin  = 8'h4A;
        St   = 1'b1;
        cyc();
        St = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ign_busy", Busy, 1);
            St   = (i == 1) || (i == 4);
            Xin  = 8'($urandom);
            Yin  = 8'($urandom);
            Mode = 1'($urandom);
            Acc  = 1'($urandom);
            cyc();
        end
        St = 1'b0;
        chk("ign_done", Done, 1);
        chk("ign_sum", Sum, 8'h7F);
        chk("ign_cout", Cout, 0);
        cyc();
        chk("ign_single", Done, 0);
        chk("ign_noq", Busy, 0);
        cyc();
        chk("ign_noq2", Busy, 0);

        run_op("pre_rst", 1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

        // Async reset with counter at 4.
        Acc  = 1'b0;
        Mode = 1'b0;
        Xin  = 8'hAA;
        Yin  = 8'h11;
        St   = 1'b1;
        cyc();
        St = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("mid_busy", Busy, 1);
        #2 Rst_n = 1'b0;
        #0.5;
        chk("arst_busy", Busy, 0);
        chk("arst_sum", Sum, 0);
        chk("arst_cout", Cout, 0);
        chk("arst_done", Done, 0);
        #0.5 Rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("arst_nodone", Done, 0);
        end

        run_op("post_rst", 1'b0, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);

        // St held high: restart one cycle after Done.
        Acc  = 1'b0;
        Mode = 1'b0;
        Xin  = 8'h01;
        Yin  = 8'h02;
        St   = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) cyc();
        chk("b2b_done", Done, 1);
        chk("b2b_sum", Sum, 8'h03);
        Acc = 1'b1;
        Yin = 8'h04;
        cyc();
        chk("b2b_idle", Busy, 0);
        cyc();
        chk("b2b_restart", Busy, 1);
        St = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        chk("b2b_done2", Done, 1);
        chk("b2b_sum2", Sum, 8'h07);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
